// File: rtl/md_acc_pkg.sv
// Shared types and constants for the force accumulation sequencer.
package md_acc_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ID_W_DEF   = 9;
    localparam int unsigned CNT_W_DEF  = 8;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        FLUSH = 2'd2
    } acc_state_e;

endpackage

// File: rtl/force_acc_seq_fp_acc.sv
// FP_ACC: single-cycle fp32 adder with result register (result <= ax + ay when ena).
// Round-to-nearest-even; subnormal inputs and results are flushed to zero.
module FP_ACC (
    input  logic        clk,
    input  logic        clr,
    input  logic        ena,
    input  logic [31:0] ax,
    input  logic [31:0] ay,
    output logic [31:0] result
);

    logic [31:0]       result_q, sum_d;
    logic              swap, eff_sub, found;
    logic [31:0]       big, sml;
    logic [7:0]        e_big, e_sml, diff;
    logic [26:0]       m_big, m_sml, m_aln, lost_mask, nrm;
    logic [27:0]       raw;
    logic [4:0]        lz;
    logic signed [9:0] e_nrm;
    logic              rnd_up;
    logic [24:0]       m_rnd;
    logic [22:0]       frac;

    always_comb begin
        swap      = ay[30:0] > ax[30:0];
        big       = swap ? ay : ax;
        sml       = swap ? ax : ay;
        e_big     = big[30:23];
        e_sml     = sml[30:23];
        m_big     = (e_big == 8'd0) ? '0 : {1'b1, big[22:0], 3'b000};
        m_sml     = (e_sml == 8'd0) ? '0 : {1'b1, sml[22:0], 3'b000};
        diff      = e_big - e_sml;
        eff_sub   = big[31] ^ sml[31];
        lost_mask = '0;

        // Alignment keeps a sticky bit so shifted-out mass still affects rounding.
        if (diff >= 8'd27) begin
            m_aln = {26'b0, |m_sml};
        end else begin
            lost_mask = (27'd1 << diff) - 27'd1;
            m_aln     = (m_sml >> diff) | {26'b0, |(m_sml & lost_mask)};
        end

        raw = eff_sub ? ({1'b0, m_big} - {1'b0, m_aln}) : ({1'b0, m_big} + {1'b0, m_aln});

        lz    = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 27; i++) begin
            if (!found && raw[26 - i]) begin
                lz    = 5'(i);
                found = 1'b1;
            end
        end

        if (raw[27]) begin
            nrm   = raw[27:1] | {26'b0, raw[0]};
            e_nrm = $signed({2'b00, e_big}) + 10'sd1;
        end else begin
            nrm   = raw[26:0] << lz;
            e_nrm = $signed({2'b00, e_big}) - $signed({5'b00000, lz});
        end

        rnd_up = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
        m_rnd  = {1'b0, nrm[26:3]} + {24'b0, rnd_up};
        frac   = m_rnd[24] ? m_rnd[23:1] : m_rnd[22:0];
        if (m_rnd[24]) begin
            e_nrm = e_nrm + 10'sd1;
        end

        sum_d = {big[31], e_nrm[7:0], frac};
        if (e_big == 8'hFF) begin
            sum_d = ((e_sml == 8'hFF && eff_sub) || big[22:0] != 23'd0) ? 32'h7FC0_0000 : big;
        end else if (raw == 28'd0) begin
            sum_d = {big[31] & sml[31], 31'b0};
        end else if (e_nrm >= 10'sd255) begin
            sum_d = {big[31], 8'hFF, 23'b0};
        end else if (e_nrm <= 10'sd0) begin
            sum_d = {big[31], 31'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            result_q <= '0;
        end else if (ena) begin
            result_q <= sum_d;
        end
    end

    assign result = result_q;

endmodule

// File: rtl/force_acc_seq.sv
// Sequencer turning a tagged fp32 partial-force stream into one summed force per group.
// Optional id consistency check enabled by defining ACC_IDCHK_EN.
module force_acc_seq
    import md_acc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_W_DEF,
    parameter int unsigned ID_WIDTH   = ID_W_DEF,
    parameter int unsigned CNT_WIDTH  = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [ID_WIDTH-1:0]   in_id,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ID_WIDTH-1:0]   out_id,
    output logic [CNT_WIDTH-1:0]  out_cnt,
    output logic                  err
);

    acc_state_e            state_q, state_d;
    logic [ID_WIDTH-1:0]   cur_id_q, cur_id_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [ID_WIDTH-1:0]   out_id_q, out_id_d;
    logic [CNT_WIDTH-1:0]  out_cnt_q, out_cnt_d;
    logic                  slot_free, accept, capture;
    logic [DATA_WIDTH-1:0] acc_ay, acc_result;
`ifdef ACC_IDCHK_EN
    logic                  err_q, err_d;
`endif

    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = !rst && (state_q != FLUSH || slot_free);
    assign accept    = in_valid && in_ready;
    assign capture   = (state_q == FLUSH) && slot_free;
    // Only an open group feeds back; every group's first sample is seeded from zero.
    assign acc_ay    = (state_q == ACC) ? acc_result : DATA_WIDTH'(FP_ZERO);

    FP_ACC u_fp_acc (
        .clk    (clk),
        .clr    (rst),
        .ena    (accept),
        .ax     (in_data),
        .ay     (acc_ay),
        .result (acc_result)
    );

    always_comb begin
        state_d     = state_q;
        cur_id_d    = cur_id_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        out_cnt_d   = out_cnt_q;
`ifdef ACC_IDCHK_EN
        err_d       = err_q;
`endif

        if (capture) begin
            state_d     = IDLE;
            out_valid_d = 1'b1;
            out_data_d  = acc_result;
            out_id_d    = cur_id_q;
            out_cnt_d   = cnt_q;
        end

        // A sample taken in FLUSH overrides the IDLE fallback above and opens the next group.
        if (accept) begin
            state_d = in_last ? FLUSH : ACC;
            if (state_q == ACC) begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
`ifdef ACC_IDCHK_EN
                if (in_id != cur_id_q) begin
                    err_d = 1'b1;
                end
`endif
            end else begin
                cur_id_d = in_id;
                cnt_d    = CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_id_q    <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            out_cnt_q   <= '0;
`ifdef ACC_IDCHK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cur_id_q    <= cur_id_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            out_cnt_q   <= out_cnt_d;
`ifdef ACC_IDCHK_EN
            err_q       <= err_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign out_cnt   = out_cnt_q;
`ifdef ACC_IDCHK_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_force_acc_seq.sv
// Self-checking bench for force_acc_seq: directed vectors, corner sequences, random groups.
module tb_force_acc_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last;
    logic [31:0] in_data;
    logic [8:0]  in_id;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic [8:0]  out_id;
    logic [7:0]  out_cnt;
    logic        err;

    int total = 0;
    int bad   = 0;

    force_acc_seq #(.DATA_WIDTH(32), .ID_WIDTH(9), .CNT_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_id     (in_id),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_cnt   (out_cnt),
        .err       (err)
    );

    always #5 clk = ~clk;

`ifdef ACC_IDCHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic [8:0]  id;
        logic        last;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_data;
        logic [8:0]  e_id;
        logic [7:0]  e_cnt;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [8:0]  id;
        logic [7:0]  cnt;
    } exp_t;

    vec_t tbl[10];
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Drive at the falling edge, then settle so outputs and in_ready can be sampled.
    task automatic apply(input logic v, input logic [31:0] d, input logic [8:0] id,
                         input logic last, input logic ordy);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_id     = id;
        in_last   = last;
        out_ready = ordy;
        #1;
    endtask

    // Value q/4 encoded as fp32; exact for |q| < 2^24.
    function automatic logic [31:0] q2fp(input int q);
        logic [31:0] mag, sh;
        logic [31:0] r;
        int p;
        if (q == 0) return 32'h0;
        mag = (q < 0) ? 32'(-q) : 32'(q);
        p = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) p = i;
        sh = mag << (23 - p);
        r[31]    = (q < 0);
        r[30:23] = 8'(127 + p - 2);
        r[22:0]  = sh[22:0];
        return r;
    endfunction

    initial begin
        int glen, gpos, gid, pk;
        logic pv;
        int  m_open, m_sum, m_cnt;
        logic [8:0] m_id;
        exp_t e;

        tbl[0] = '{1'b1, 32'h3F800000, 9'd5, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 9'd0, 8'd0};
        tbl[1] = '{1'b1, 32'h40000000, 9'd5, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 9'd0, 8'd0};
        tbl[2] = '{1'b1, 32'h40400000, 9'd5, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 9'd0, 8'd0};
        tbl[3] = '{1'b0, 32'h0,        9'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 9'd0, 8'd0};
        tbl[4] = '{1'b0, 32'h0,        9'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40C00000, 9'd5, 8'd3};
        tbl[5] = '{1'b1, 32'h3F000000, 9'd1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 9'd0, 8'd0};
        tbl[6] = '{1'b1, 32'h3F800000, 9'd2, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 9'd0, 8'd0};
        tbl[7] = '{1'b0, 32'h0,        9'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h3F000000, 9'd1, 8'd1};
        tbl[8] = '{1'b0, 32'h0,        9'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h3F800000, 9'd2, 8'd1};
        tbl[9] = '{1'b0, 32'h0,        9'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 9'd0, 8'd0};

        rst = 1'b1;
        apply(1'b0, 32'h0, 9'd0, 1'b0, 1'b0);
        apply(1'b0, 32'h0, 9'd0, 1'b0, 1'b0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        chk("rst_out_cnt", 32'(out_cnt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        apply(1'b0, 32'h0, 9'd0, 1'b0, 1'b1);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].v, tbl[i].d, tbl[i].id, tbl[i].last, tbl[i].ordy);
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            if (tbl[i].e_ov) begin
                chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].e_data);
                chk($sformatf("vec%0d_out_id", i), 32'(out_id), 32'(tbl[i].e_id));
                chk($sformatf("vec%0d_out_cnt", i), 32'(out_cnt), 32'(tbl[i].e_cnt));
            end
        end

        // Output slot blocked while a finished group waits in FLUSH.
        apply(1'b1, 32'h3F800000, 9'd9, 1'b1, 1'b0);
        chk("bp_d0_in_ready", 32'(in_ready), 32'd1);
        apply(1'b1, 32'h3F800000, 9'd7, 1'b0, 1'b0);
        chk("bp_d1_in_ready", 32'(in_ready), 32'd1);
        apply(1'b1, 32'h3F800000, 9'd7, 1'b1, 1'b0);
        chk("bp_d2_in_ready", 32'(in_ready), 32'd1);
        chk("bp_d2_out_id", 32'(out_id), 32'd9);
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 32'h40800000, 9'd8, 1'b1, 1'b0);
            chk($sformatf("bp_hold%0d_in_ready", i), 32'(in_ready), 32'd0);
            chk($sformatf("bp_hold%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp_hold%0d_out_data", i), out_data, 32'h3F800000);
        end
        apply(1'b1, 32'h40800000, 9'd8, 1'b1, 1'b1);
        chk("bp_rel_in_ready", 32'(in_ready), 32'd1);
        chk("bp_rel_out_id", 32'(out_id), 32'd9);
        apply(1'b0, 32'h0, 9'd0, 1'b0, 1'b1);
        chk("bp_g7_out_valid", 32'(out_valid), 32'd1);
        chk("bp_g7_out_data", out_data, 32'h40000000);
        chk("bp_g7_out_id", 32'(out_id), 32'd7);
        chk("bp_g7_out_cnt", 32'(out_cnt), 32'd2);
        apply(1'b0, 32'h0, 9'd0, 1'b0, 1'b1);
        chk("bp_g8_out_data", out_data, 32'h40800000);
        chk("bp_g8_out_id", 32'(out_id), 32'd8);
        chk("bp_g8_out_cnt", 32'(out_cnt), 32'd1);
        apply(1'b0, 32'h0, 9'd0, 1'b0, 1'b1);
        chk("bp_end_out_valid", 32'(out_valid), 32'd0);

        // Reset in the middle of a group.
        apply(1'b1, 32'h3F800000, 9'd6, 1'b0, 1'b1);
        apply(1'b1, 32'h3F800000, 9'd6, 1'b0, 1'b1);
        rst = 1'b1;
        apply(1'b0, 32'h0, 9'd0, 1'b0, 1'b1);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        apply(1'b0, 32'h0, 9'd0, 1'b0, 1'b1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", out_data, 32'd0);
        chk("midrst_out_id", 32'(out_id), 32'd0);
        chk("midrst_out_cnt", 32'(out_cnt), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 32'h0, 9'd0, 1'b0, 1'b1);
            chk($sformatf("midrst_quiet%0d_out_valid", i), 32'(out_valid), 32'd0);
        end
        apply(1'b1, 32'h40000000, 9'd11, 1'b1, 1'b1);
        apply(1'b0, 32'h0, 9'd0, 1'b0, 1'b1);
        apply(1'b0, 32'h0, 9'd0, 1'b0, 1'b1);
        chk("midrst_new_out_valid", 32'(out_valid), 32'd1);
        chk("midrst_new_out_data", out_data, 32'h40000000);
        chk("midrst_new_out_id", 32'(out_id), 32'd11);
        chk("midrst_new_out_cnt", 32'(out_cnt), 32'd1);

        // Mismatched id inside an open group.
        apply(1'b1, 32'h3F800000, 9'd3, 1'b0, 1'b1);
        apply(1'b1, 32'h3F800000, 9'd4, 1'b1, 1'b1);
        apply(1'b0, 32'h0, 9'd0, 1'b0, 1'b1);
        chk("idchk_err", 32'(err), 32'(EXP_ERR));
        apply(1'b0, 32'h0, 9'd0, 1'b0, 1'b1);
        chk("idchk_out_data", out_data, 32'h40000000);
        chk("idchk_out_id", 32'(out_id), 32'd3);
        chk("idchk_out_cnt", 32'(out_cnt), 32'd2);
        apply(1'b1, 32'h3F800000, 9'd12, 1'b1, 1'b1);
        apply(1'b0, 32'h0, 9'd0, 1'b0, 1'b1);
        apply(1'b0, 32'h0, 9'd0, 1'b0, 1'b1);
        chk("idchk_sticky_err", 32'(err), 32'(EXP_ERR));
        chk("idchk_clean_out_data", out_data, 32'h3F800000);

        // Counter saturation with 2^8+3 zero samples.
        for (int i = 0; i < 259; i++) begin
            apply(1'b1, 32'h0, 9'd20, (i == 258), 1'b1);
        end
        apply(1'b0, 32'h0, 9'd0, 1'b0, 1'b1);
        apply(1'b0, 32'h0, 9'd0, 1'b0, 1'b1);
        chk("sat_out_valid", 32'(out_valid), 32'd1);
        chk("sat_out_data", out_data, 32'd0);
        chk("sat_out_id", 32'(out_id), 32'd20);
        chk("sat_out_cnt", 32'(out_cnt), 32'd255);
        apply(1'b0, 32'h0, 9'd0, 1'b0, 1'b1);

        // Random groups against an exact quarter-unit integer model.
        m_open = 0; m_sum = 0; m_cnt = 0; m_id = '0;
        glen = $urandom_range(1, 6); gpos = 0; gid = $urandom_range(0, 511);
        pk = int'($urandom_range(0, 128)) - 64;
        for (int c = 0; c < 3000; c++) begin
            pv = ($urandom_range(0, 9) < 7);
            apply(pv, q2fp(pk), 9'(gid), (gpos == glen - 1), ($urandom_range(0, 9) < 7));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_out_data", out_data, e.d);
                    chk("rnd_out_id", 32'(out_id), 32'(e.id));
                    chk("rnd_out_cnt", 32'(out_cnt), 32'(e.cnt));
                end
            end
            if (in_valid && in_ready) begin
                if (m_open == 0) begin
                    m_open = 1; m_sum = pk; m_cnt = 1; m_id = 9'(gid);
                end else begin
                    m_sum += pk;
                    m_cnt++;
                end
                if (in_last) begin
                    e.d   = q2fp(m_sum);
                    e.id  = m_id;
                    e.cnt = 8'((m_cnt > 255) ? 255 : m_cnt);
                    exp_q.push_back(e);
                    m_open = 0;
                end
                gpos++;
                if (gpos == glen) begin
                    glen = $urandom_range(1, 6); gpos = 0; gid = $urandom_range(0, 511);
                end
                pk = int'($urandom_range(0, 128)) - 64;
            end
        end
        // Finish any open group so everything drains.
        while (m_open != 0) begin
            apply(1'b1, q2fp(pk), 9'(gid), (gpos == glen - 1), 1'b1);
            if (out_valid && out_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("drain_out_data", out_data, e.d);
                chk("drain_out_id", 32'(out_id), 32'(e.id));
            end
            if (in_valid && in_ready) begin
                m_sum += pk;
                m_cnt++;
                if (in_last) begin
                    e.d = q2fp(m_sum); e.id = m_id; e.cnt = 8'((m_cnt > 255) ? 255 : m_cnt);
                    exp_q.push_back(e);
                    m_open = 0;
                end
                gpos++;
                pk = int'($urandom_range(0, 128)) - 64;
            end
        end
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            apply(1'b0, 32'h0, 9'd0, 1'b0, 1'b1);
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                chk("drain_out_data", out_data, e.d);
                chk("drain_out_id", 32'(out_id), 32'(e.id));
                chk("drain_out_cnt", 32'(out_cnt), 32'(e.cnt));
            end
        end
        chk("drain_pending_groups", 32'(exp_q.size()), 32'd0);
        chk("rnd_err", 32'(err), 32'(EXP_ERR));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/force_acc_seq.md
# force_acc_seq

Sequencer that wraps the single-cycle FP_ACC accumulator. It turns a tagged stream of fp32 partial forces into one summed force per group, one group per target particle. It sits between the force-evaluation pipelines and the force cache write port. It handles group start (zero-seeded load), group end (flush and capture), and output backpressure, and holds the accumulator while the output slot is blocked.

## Interface
- DATA_WIDTH, 32: fp32 operand and result width
- ID_WIDTH, 9: particle/group identifier width
- CNT_WIDTH, 8: per-group sample counter width (saturating)
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  controller accepts a sample this cycle
- in_data  in  DATA_WIDTH  fp32 partial force
- in_id  in  ID_WIDTH  group identifier
- in_last  in  1  final sample of the group
- out_valid  out  1  summed result held in output slot
- out_ready  in  1  downstream consumes slot
- out_data  out  DATA_WIDTH  fp32 group sum
- out_id  out  ID_WIDTH  group identifier of out_data
- out_cnt  out  CNT_WIDTH  samples summed in the group
- err  out  1  sticky protocol error (ACC_IDCHK_EN only; tied 0 otherwise)

## Operation
- Transfer happens when in_valid && in_ready, and when out_valid && out_ready.
- States:
  - IDLE: no group open.
  - ACC: group open.
  - FLUSH: result register holds the final sum and awaits capture.
- Accepted sample in IDLE, or the first sample after FLUSH: drives FP_ACC with ax=in_data, ay=0, ena=1. Latches cur_id=in_id and sets cnt=1.
- Accepted sample in ACC: drives ax=in_data, ay=FP_ACC result (feedback), ena=1. cnt increments and saturates at all-ones.
- Accepted sample with in_last=1: next state is FLUSH, from either IDLE or ACC. A single-sample group is legal.
- FLUSH: the result register holds the final sum.
  - If the slot is free (out_valid=0 or out_ready=1), the slot loads {result, cur_id, cnt}.
  - In the same cycle, in_ready=1 and a new first sample may be accepted. That sample goes to ACC, or to FLUSH if it also has in_last.
  - If the slot is blocked, in_ready=0, ena=0, and the controller stays in FLUSH. The result is preserved.
- ena=0 whenever no sample is accepted. FP_ACC clr is driven only by rst.
- The output slot holds its value until consumed. out_valid drops after the transfer unless it is reloaded in the same cycle.
- Reset mid-group discards the partial sum. All state returns to IDLE.
- Reset values: in_ready=0 during rst and 1 after. out_valid=0, out_data=0, out_id=0, out_cnt=0, err=0. State is IDLE.

## Timing
- FP_ACC latency is 1 cycle. A sample accepted in cycle t is in result at t+1.
- Last sample accepted at t gives FLUSH at t+1 and out_valid=1 at t+2 when the slot is free.
- Back-to-back groups sustain 1 sample/cycle with no bubbles, provided out_ready is held high.
- in_ready is combinational from state, out_valid and out_ready.
- There is no combinational path from in_data to out_data.

## Configuration
- ACC_IDCHK_EN defined: in ACC, an accepted sample with in_id != cur_id sets err. err is sticky until rst. The sample is still summed into the open group.
- ACC_IDCHK_EN undefined: no id comparison, err tied 0, and cur_id is taken from the first sample only.

## Structure
- Shared package md_acc_pkg holds:
  - the state enum (IDLE/ACC/FLUSH)
  - fp32 constant FP_ZERO=32'h00000000
  - default widths
- Exactly one sub-module: the existing FP_ACC instance, driven by seeding mux, ena gate and rst-based clr. No other hierarchy.

## Test plan
- Group id=5 of 1.0, 2.0, 3.0 (0x3F800000, 0x40000000, 0x40400000, last on 3rd), out_ready=1 -> one output: out_data=0x40C00000, out_id=5, out_cnt=3, two cycles after the last sample.
- Back-to-back single-sample groups id=1 (0.5=0x3F000000) and id=2 (1.0), out_ready=1 -> outputs 0x3F000000/1 then 0x3F800000/2 on consecutive cycles, with in_ready never low.
- Group id=7 of 1.0, 1.0 completes while the slot is full and out_ready=0 for 4 cycles -> in_ready=0 and state held in FLUSH. After the release, out_data=0x40000000 and the next group's first sample is seeded from 0.
- rst asserted after 2 samples of a 3-sample group -> outputs reset to 0 and no output is produced. A new group 2.0 with last gives 0x40000000 and cnt=1.
- ACC_IDCHK_EN: group id=3 with a second sample tagged id=4 -> err=1 and sticky. The sum includes both samples.
- Group of 2^CNT_WIDTH+3 samples of 0x00000000 -> out_cnt saturates at all-ones and out_data=0.
